// File: rtl/bitcell_array_if.sv
// Request/response bundle for bitcell_array: one-per-cycle read/write/clear requests
// from the chip-level memory interface, registered read data and status back.
interface bitcell_array_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             sel;
    logic             rw;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic             clear;
    logic [WIDTH-1:0] cellOut;
    logic             valid;
    logic             busy;

    modport master (
        output sel, rw, addr, data, clear,
        input  cellOut, valid, busy
    );

    modport slave (
        input  sel, rw, addr, data, clear,
        output cellOut, valid, busy
    );
endinterface

// File: rtl/bitcell_array.sv
// WIDTH x DEPTH synchronous word array with registered read data, a valid strobe and a
// sequencer that zeroes every word after reset or on a clear request.
module bitcell_array #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    bitcell_array_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrLast = AW'(DEPTH - 1);

    typedef enum logic {StClear, StIdle} state_e;

    state_e           state_q;
    logic [AW-1:0]    ptr_q;
    logic [WIDTH-1:0] cell_out_q;
    logic             valid_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             addr_ok;

    // Only reachable when DEPTH is not a power of two.
    assign addr_ok = 32'(bus.addr) < DEPTH;

    // Storage is deliberately left out of reset: only the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            ptr_q      <= '0;
            cell_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StClear: begin
                    mem_q[ptr_q] <= '0;
                    if (ptr_q == PtrLast) begin
                        state_q <= StIdle;
                        ptr_q   <= '0;
                    end else begin
                        ptr_q <= ptr_q + AW'(1);
                    end
                end
                StIdle: begin
                    if (bus.clear) begin
                        state_q <= StClear;
                        ptr_q   <= '0;
                    end else if (bus.sel) begin
                        if (bus.rw) begin
                            if (addr_ok) begin
                                mem_q[bus.addr] <= bus.data;
                            end
                        end else begin
                            cell_out_q <= addr_ok ? mem_q[bus.addr] : '0;
                            valid_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StClear;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign bus.cellOut = cell_out_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = (state_q == StClear);
endmodule

// File: tb/tb_bitcell_array.sv
// Scoreboard bench for bitcell_array: an 8x8 instance driven against a behavioural model,
// plus a 16x5 instance for the non-power-of-two depth case.
module tb_bitcell_array;
    logic clk;
    logic rst;
    logic rst_b;

    bitcell_array_if #(.WIDTH(8),  .DEPTH(8)) bus_a ();
    bitcell_array_if #(.WIDTH(16), .DEPTH(5)) bus_b ();

    bitcell_array #(.WIDTH(8), .DEPTH(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bitcell_array #(.WIDTH(16), .DEPTH(5)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic       c;
        logic       s;
        logic       r;
        logic [2:0] a;
        logic [7:0] d;
    } stim_t;

    int passed = 0;
    int total  = 0;

    // Model of the 8x8 instance
    logic [7:0] m_mem [8];
    int         m_left = 0;
    int         m_ptr  = 0;
    logic       exp_busy;
    logic       exp_valid;
    logic [7:0] exp_hold;
    logic [7:0] exp_q [$];

    // 16x5 instance scoreboard
    logic [15:0] exp_qb [$];

    function automatic stim_t mk(input logic rs, input logic c, input logic s, input logic r,
                                 input logic [2:0] a, input logic [7:0] d);
        stim_t t;
        t.rs = rs; t.c = c; t.s = s; t.r = r; t.a = a; t.d = d;
        return t;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endfunction

    function automatic stim_t wr(input logic [2:0] a, input logic [7:0] d);
        return mk(1'b0, 1'b0, 1'b1, 1'b1, a, d);
    endfunction

    function automatic stim_t rd(input logic [2:0] a);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, a, 8'h00);
    endfunction

    // Drive one request into dut_a, advance the model by one edge, then wait past the edge.
    task automatic issue(input stim_t t);
        rst         = t.rs;
        bus_a.clear = t.c;
        bus_a.sel   = t.s;
        bus_a.rw    = t.r;
        bus_a.addr  = t.a;
        bus_a.data  = t.d;
        if (t.rs) begin
            m_left    = 8;
            m_ptr     = 0;
            exp_hold  = 8'h00;
            exp_valid = 1'b0;
            exp_q.delete();
        end else if (m_left > 0) begin
            m_mem[m_ptr] = 8'h00;
            m_ptr++;
            m_left--;
            exp_valid = 1'b0;
        end else if (t.c) begin
            m_left    = 8;
            m_ptr     = 0;
            exp_valid = 1'b0;
        end else if (t.s && t.r) begin
            m_mem[t.a] = t.d;
            exp_valid  = 1'b0;
        end else if (t.s) begin
            exp_q.push_back(m_mem[t.a]);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        exp_busy = (m_left > 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st [$];
        logic [7:0] want;
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        for (int i = 0; i < 8; i++) st.push_back(idle());
        for (int i = 0; i < 8; i++) st.push_back(rd(3'(i)));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            issue(st[i]);
            want     = exp_valid ? exp_q.pop_front() : exp_hold;
            exp_hold = want;
            total++;
            if ({bus_a.busy, bus_a.valid, bus_a.cellOut} !== {exp_busy, exp_valid, want})
                $display("FAIL reset[%0d]: busy/valid/cellOut got %b/%b/%h want %b/%b/%h", i,
                         bus_a.busy, bus_a.valid, bus_a.cellOut, exp_busy, exp_valid, want);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        stim_t st [$];
        logic [7:0] want;
        st.push_back(wr(3'd3, 8'hA5));
        st.push_back(wr(3'd4, 8'h5A));
        st.push_back(rd(3'd3));
        st.push_back(rd(3'd4));
        st.push_back(idle());
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            issue(st[i]);
            want     = exp_valid ? exp_q.pop_front() : exp_hold;
            exp_hold = want;
            total++;
            if ({bus_a.busy, bus_a.valid, bus_a.cellOut} !== {exp_busy, exp_valid, want})
                $display("FAIL write_read[%0d]: busy/valid/cellOut got %b/%b/%h want %b/%b/%h",
                         i, bus_a.busy, bus_a.valid, bus_a.cellOut, exp_busy, exp_valid, want);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st [$];
        logic [7:0] want;
        for (int i = 0; i < 8; i++) st.push_back(wr(3'(i), 8'($urandom_range(0, 255))));
        st.push_back(wr(3'd0, 8'h3C));
        for (int i = 7; i >= 0; i--) st.push_back(rd(3'(i)));
        st.push_back(rd(3'd0));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            issue(st[i]);
            want     = exp_valid ? exp_q.pop_front() : exp_hold;
            exp_hold = want;
            total++;
            if ({bus_a.busy, bus_a.valid, bus_a.cellOut} !== {exp_busy, exp_valid, want})
                $display("FAIL back_to_back[%0d]: busy/valid/cellOut got %b/%b/%h want %b/%b/%h",
                         i, bus_a.busy, bus_a.valid, bus_a.cellOut, exp_busy, exp_valid, want);
            else passed++;
        end
    endtask

    task automatic test_clear();
        stim_t st [$];
        logic [7:0] want;
        for (int i = 0; i < 8; i++) st.push_back(wr(3'(i), 8'hFF));
        // Clear wins over a same-cycle write; a clear mid-sweep must not restart it.
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 8'h11));
        st.push_back(idle());
        st.push_back(idle());
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        for (int i = 0; i < 5; i++) st.push_back(idle());
        for (int i = 0; i < 8; i++) st.push_back(rd(3'(i)));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            issue(st[i]);
            want     = exp_valid ? exp_q.pop_front() : exp_hold;
            exp_hold = want;
            total++;
            if ({bus_a.busy, bus_a.valid, bus_a.cellOut} !== {exp_busy, exp_valid, want})
                $display("FAIL clear[%0d]: busy/valid/cellOut got %b/%b/%h want %b/%b/%h", i,
                         bus_a.busy, bus_a.valid, bus_a.cellOut, exp_busy, exp_valid, want);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_clear();
        stim_t st [$];
        logic [7:0] want;
        st.push_back(wr(3'd2, 8'h33));
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00));
        for (int i = 0; i < 3; i++) st.push_back(idle());
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00));
        st.push_back(wr(3'd2, 8'h77));
        for (int i = 0; i < 7; i++) st.push_back(idle());
        st.push_back(rd(3'd2));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            issue(st[i]);
            want     = exp_valid ? exp_q.pop_front() : exp_hold;
            exp_hold = want;
            total++;
            if ({bus_a.busy, bus_a.valid, bus_a.cellOut} !== {exp_busy, exp_valid, want})
                $display("FAIL reset_mid_clear[%0d]: busy/valid/cellOut got %b/%b/%h want %b/%b/%h",
                         i, bus_a.busy, bus_a.valid, bus_a.cellOut, exp_busy, exp_valid, want);
            else passed++;
        end
    endtask

    task automatic test_reset_on_read();
        stim_t st [$];
        logic [7:0] want;
        st.push_back(wr(3'd1, 8'h9C));
        st.push_back(rd(3'd1));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h00));
        for (int i = 0; i < 8; i++) st.push_back(idle());
        st.push_back(rd(3'd1));
        for (int i = 0; i < st.size(); i++) begin
            issue(st[i]);
            want     = exp_valid ? exp_q.pop_front() : exp_hold;
            exp_hold = want;
            total++;
            if ({bus_a.busy, bus_a.valid, bus_a.cellOut} !== {exp_busy, exp_valid, want})
                $display("FAIL reset_on_read[%0d]: busy/valid/cellOut got %b/%b/%h want %b/%b/%h",
                         i, bus_a.busy, bus_a.valid, bus_a.cellOut, exp_busy, exp_valid, want);
            else passed++;
        end
    endtask

    // 16x5 instance: reset sweep length, and out-of-range write/read at addresses 5..7.
    task automatic test_param();
        logic [15:0] want;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({bus_b.busy, bus_b.valid, bus_b.cellOut} !== {1'b1, 1'b0, 16'h0000})
            $display("FAIL param_reset: busy/valid/cellOut got %b/%b/%h want 1/0/0000",
                     bus_b.busy, bus_b.valid, bus_b.cellOut);
        else passed++;
        rst_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus_b.busy !== (i < 5))
                $display("FAIL param_sweep[%0d]: busy got %b want %b", i, bus_b.busy, (i < 5));
            else passed++;
        end
        for (int i = 0; i < 6; i++) begin
            bus_b.sel = 1'b1;
            unique case (i)
                0: begin bus_b.rw = 1'b1; bus_b.addr = 3'd4; bus_b.data = 16'hBEEF; end
                1: begin bus_b.rw = 1'b1; bus_b.addr = 3'd6; bus_b.data = 16'h1234; end
                2: begin bus_b.rw = 1'b0; bus_b.addr = 3'd4; exp_qb.push_back(16'hBEEF); end
                3: begin bus_b.rw = 1'b0; bus_b.addr = 3'd6; exp_qb.push_back(16'h0000); end
                4: begin bus_b.rw = 1'b0; bus_b.addr = 3'd5; exp_qb.push_back(16'h0000); end
                default: bus_b.sel = 1'b0;
            endcase
            @(posedge clk);
            #1;
            if (i >= 2 && i <= 4) begin
                want = exp_qb.pop_front();
                total++;
                if ({bus_b.valid, bus_b.cellOut} !== {1'b1, want})
                    $display("FAIL param_read[%0d]: valid/cellOut got %b/%h want 1/%h", i,
                             bus_b.valid, bus_b.cellOut, want);
                else passed++;
            end else begin
                total++;
                if ({bus_b.busy, bus_b.valid} !== 2'b00)
                    $display("FAIL param_idle[%0d]: busy/valid got %b/%b want 0/0", i,
                             bus_b.busy, bus_b.valid);
                else passed++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_mem[i] = 8'hEE;
        exp_hold    = 8'h00;
        rst         = 1'b1;
        rst_b       = 1'b1;
        bus_a.sel   = 1'b0;
        bus_a.rw    = 1'b0;
        bus_a.addr  = '0;
        bus_a.data  = '0;
        bus_a.clear = 1'b0;
        bus_b.sel   = 1'b0;
        bus_b.rw    = 1'b0;
        bus_b.addr  = '0;
        bus_b.data  = '0;
        bus_b.clear = 1'b0;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        test_reset_on_read();
        test_param();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
